// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the core (master) and a
// memory responder (slave). The initiator holds req and the request fields
// stable until it sees ack; rdata/ack/err are driven by the responder.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked data-memory responder for the CPU data port.
// Word-addressed RAM of 2**ADDR_W 32-bit words, WAIT_CYC extra wait states
// before a one-cycle ack, byte-enable stores, misalignment and range checks.
// Optional feature macro: DMEM_CYCCNT_EN maps a 32-bit free-running cycle
// counter at byte address 0xFFFFFFFC (readable, writable with be=4'b1111).
// Store write and rdata capture both happen on the edge that enters ACK.
module dmem_responder #(
    parameter int ADDR_W   = 8,
    parameter int WAIT_CYC = 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              commit_s;

    // Request fields captured when the request is accepted in IDLE
    logic              we_r;
    logic [31:0]       addr_r;
    logic [31:0]       wdata_r;
    logic [3:0]        be_r;

    // Fields of the access being committed: live bus in IDLE (zero-wait
    // case commits on the accepting edge), latched copy otherwise
    logic              acc_we_s;
    logic [31:0]       acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic [3:0]        acc_be_s;

    logic [ADDR_W-1:0] idx_s;
    logic              misalign_s;
    logic              oor_s;
    logic              is_cnt_s;
    logic              err_s;
    logic              ram_wr_s;
    logic              rd_cap_s;
    logic [31:0]       ram_q_s;
    logic [31:0]       rd_val_s;

    logic [31:0]       mem_r [DEPTH];

    logic [31:0]       rdata_r;
    logic              ack_r;
    logic              err_r;

`ifdef DMEM_CYCCNT_EN
    logic [31:0]       cyccnt_r;
    logic              cnt_wr_s;
`endif

    // Select the field source for the access that may commit this cycle
    always_comb begin
        if (state_r == ST_IDLE) begin
            acc_we_s    = bus.we;
            acc_addr_s  = bus.addr;
            acc_wdata_s = bus.wdata;
            acc_be_s    = bus.be;
        end else begin
            acc_we_s    = we_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
            acc_be_s    = be_r;
        end
    end

    // Address decode, error classification and commit qualifiers
    always_comb begin
        idx_s      = acc_addr_s[ADDR_W+1:2];
        misalign_s = |acc_addr_s[1:0];
        oor_s      = |acc_addr_s[31:ADDR_W+2];
`ifdef DMEM_CYCCNT_EN
        is_cnt_s   = (acc_addr_s == 32'hFFFF_FFFC);
`else
        is_cnt_s   = 1'b0;
`endif
        err_s      = misalign_s | (oor_s & ~is_cnt_s);
        ram_q_s    = mem_r[idx_s];
`ifdef DMEM_CYCCNT_EN
        rd_val_s   = is_cnt_s ? cyccnt_r : ram_q_s;
`else
        rd_val_s   = ram_q_s;
`endif
        // rst has priority: a store committing on a reset edge is dropped
        ram_wr_s   = commit_s & ~rst & acc_we_s & ~err_s & ~is_cnt_s;
        rd_cap_s   = commit_s & ~acc_we_s & ~err_s;
    end

    // Next-state and wait-counter logic; commit_s marks the edge entering ACK
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        commit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.req) begin
                    if (WAIT_CYC == 0) begin
                        state_s  = ST_ACK;
                        commit_s = 1'b1;
                    end else begin
                        state_s  = ST_WAIT;
                        cnt_s    = CNT_INIT;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s  = ST_ACK;
                    commit_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Capture the request fields when a request is accepted in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r    <= 1'b0;
            addr_r  <= 32'h0000_0000;
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
        end else if ((state_r == ST_IDLE) && bus.req) begin
            we_r    <= bus.we;
            addr_r  <= bus.addr;
            wdata_r <= bus.wdata;
            be_r    <= bus.be;
        end
    end

    // Registered response: ack/err for one cycle, rdata held until next load
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ack_r <= commit_s;
            err_r <= commit_s & err_s;
            if (rd_cap_s) begin
                rdata_r <= rd_val_s;
            end
        end
    end

    // Byte-masked RAM write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (ram_wr_s) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= acc_wdata_s[8*i +: 8];
                end
            end
        end
    end

`ifdef DMEM_CYCCNT_EN
    // Full-word store to the counter address reloads it; partial be is ignored
    assign cnt_wr_s = commit_s & acc_we_s & is_cnt_s & (acc_be_s == 4'b1111);

    // Free-running cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            cyccnt_r <= 32'h0000_0000;
        end else if (cnt_wr_s) begin
            cyccnt_r <= acc_wdata_s;
        end else begin
            cyccnt_r <= cyccnt_r + 32'd1;
        end
    end
`endif

    assign bus.rdata = rdata_r;
    assign bus.ack   = ack_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder: one instance with WAIT_CYC=2 for
// latency, masking, error, field-stability, reset and counter cases, and one
// with WAIT_CYC=0 for back-to-back requests. Expected values are hand-computed.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Edge counter used to measure distance between commit edges
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder_if if2 ();
    dmem_responder_if if0 ();

    dmem_responder #(.ADDR_W(8), .WAIT_CYC(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    dmem_responder #(.ADDR_W(8), .WAIT_CYC(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the WAIT_CYC=2 instance. ack must first be seen
    // right after the 2nd edge following the sampling edge (i.e. during the
    // 3rd cycle counted from the sample), with err as given, for one cycle.
    // With scramble set the request fields are altered while in WAIT.
    task automatic txn2(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input bit scramble,
                        input logic exp_err, output logic [31:0] rdata, output int ccyc);
        int lat;
        @(negedge clk);
        if2.we    = we;
        if2.addr  = addr;
        if2.wdata = wdata;
        if2.be    = be;
        if2.req   = 1'b1;
        @(posedge clk);
        #1;
        if (scramble) begin
            if2.we    = ~we;
            if2.addr  = addr ^ 32'h0000_000C;
            if2.wdata = ~wdata;
            if2.be    = ~be;
        end
        lat = 0;
        while ((if2.ack !== 1'b1) && (lat < 40)) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd2);
        check_val({tag, "_err"}, {31'd0, if2.err}, {31'd0, exp_err});
        rdata   = if2.rdata;
        ccyc    = cyc;
        if2.req = 1'b0;
        @(posedge clk);
        #1;
        check_val({tag, "_ackdrop"}, {31'd0, if2.ack}, 32'd0);
    endtask

    logic [31:0] rd;
    int          c1;
    int          c2;
    logic [31:0] a0 [8];
    logic [31:0] d0 [8];
    logic        w0 [8];

    initial begin
        if2.req = 1'b0; if2.we = 1'b0; if2.addr = 32'd0; if2.wdata = 32'd0; if2.be = 4'd0;
        if0.req = 1'b0; if0.we = 1'b0; if0.addr = 32'd0; if0.wdata = 32'd0; if0.be = 4'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_val("rst_ack", {31'd0, if2.ack}, 32'd0);
        check_val("rst_err", {31'd0, if2.err}, 32'd0);
        check_val("rst_rdata", if2.rdata, 32'd0);
        check_val("rst_ack0", {31'd0, if0.ack}, 32'd0);

        // Basic store then load
        txn2("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("st10_rdata_kept", rd, 32'd0);
        txn2("ld10", 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld10_rdata", rd, 32'hDEAD_BEEF);

        // Byte masking
        txn2("st14a", 1'b1, 32'h14, 32'h1122_3344, 4'hF, 1'b0, 1'b0, rd, c1);
        txn2("st14b", 1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, rd, c1);
        txn2("ld14", 1'b0, 32'h14, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld14_mask", rd, 32'h11BB_33DD);

        // Error cases leave RAM and rdata untouched
        txn2("st00", 1'b1, 32'h0, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b0, rd, c1);
        txn2("ld12", 1'b0, 32'h12, 32'd0, 4'hF, 1'b0, 1'b1, rd, c1);
        check_val("ld12_rdata_kept", rd, 32'h11BB_33DD);
        txn2("st12", 1'b1, 32'h12, 32'h0000_0000, 4'hF, 1'b0, 1'b1, rd, c1);
        txn2("st400", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, rd, c1);
        txn2("ld8000", 1'b0, 32'h8000_0000, 32'd0, 4'hF, 1'b0, 1'b1, rd, c1);
        txn2("ld10b", 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld10b_rdata", rd, 32'hDEAD_BEEF);
        txn2("ld00", 1'b0, 32'h0, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld00_rdata", rd, 32'h5A5A_5A5A);

        // be=0 store changes nothing; last word is in range
        txn2("st10z", 1'b1, 32'h10, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, rd, c1);
        txn2("ld10c", 1'b0, 32'h10, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld10c_rdata", rd, 32'hDEAD_BEEF);
        txn2("st3fc", 1'b1, 32'h3FC, 32'h1357_9BDF, 4'hF, 1'b0, 1'b0, rd, c1);
        txn2("ld3fc", 1'b0, 32'h3FC, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld3fc_rdata", rd, 32'h1357_9BDF);

        // Field changes after acceptance are ignored
        txn2("st18s", 1'b1, 32'h18, 32'h1234_5678, 4'hF, 1'b1, 1'b0, rd, c1);
        txn2("ld18s", 1'b0, 32'h18, 32'd0, 4'hF, 1'b1, 1'b0, rd, c1);
        check_val("ld18s_rdata", rd, 32'h1234_5678);
        txn2("ld14b", 1'b0, 32'h14, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld14b_rdata", rd, 32'h11BB_33DD);

        // Cycle counter
`ifdef DMEM_CYCCNT_EN
        txn2("stcnt", 1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 4'hF, 1'b0, 1'b0, rd, c1);
        repeat (10) @(posedge clk);
        txn2("ldcnt", 1'b0, 32'hFFFF_FFFC, 32'd0, 4'hF, 1'b0, 1'b0, rd, c2);
        check_val("ldcnt_rdata", rd, 32'h0000_0100 + 32'(c2 - c1 - 1));
`else
        txn2("stcnt", 1'b1, 32'hFFFF_FFFC, 32'h0000_0100, 4'hF, 1'b0, 1'b1, rd, c1);
        repeat (10) @(posedge clk);
        txn2("ldcnt", 1'b0, 32'hFFFF_FFFC, 32'd0, 4'hF, 1'b0, 1'b1, rd, c2);
        check_val("ldcnt_rdata_kept", rd, 32'h11BB_33DD);
`endif

        // Back-to-back on the zero-wait instance: 4 stores then 4 loads
        for (int j = 0; j < 4; j++) begin
            a0[j]     = 32'h40 + 32'(4 * j);
            d0[j]     = (32'h0101_0101 * 32'(j + 1)) ^ 32'h8000_0000;
            w0[j]     = 1'b1;
            a0[j + 4] = a0[j];
            d0[j + 4] = 32'd0;
            w0[j + 4] = 1'b0;
        end
        @(negedge clk);
        if0.we = w0[0]; if0.addr = a0[0]; if0.wdata = d0[0]; if0.be = 4'hF; if0.req = 1'b1;
        begin
            int t;
            t = 0;
            for (int k = 0; k < 16; k++) begin
                @(posedge clk);
                #1;
                check_val("b2b_ack", {31'd0, if0.ack}, ((k % 2) == 0) ? 32'd1 : 32'd0);
                if ((k % 2) == 0) begin
                    check_val("b2b_err", {31'd0, if0.err}, 32'd0);
                    if (!w0[t]) begin
                        check_val("b2b_rdata", if0.rdata, d0[t - 4]);
                    end
                    t++;
                    if (t < 8) begin
                        if0.we = w0[t]; if0.addr = a0[t]; if0.wdata = d0[t];
                    end else begin
                        if0.req = 1'b0;
                    end
                end
            end
        end

        // Reset during WAIT of a store discards it
        txn2("st20", 1'b1, 32'h20, 32'h0000_0000, 4'hF, 1'b0, 1'b0, rd, c1);
        @(negedge clk);
        if2.we = 1'b1; if2.addr = 32'h20; if2.wdata = 32'hCAFE_F00D; if2.be = 4'hF; if2.req = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b1;
        if2.req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_val("rstw_ack", {31'd0, if2.ack}, 32'd0);
        end
        check_val("rstw_rdata", if2.rdata, 32'd0);
        check_val("rstw_err", {31'd0, if2.err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn2("ld20", 1'b0, 32'h20, 32'd0, 4'hF, 1'b0, 1'b0, rd, c1);
        check_val("ld20_rdata", rd, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, run=%0d failed=%0d", n_run, n_fail);
        $fatal(1);
    end

endmodule
